// File: rtl/audio_pkg.sv
// audio_pkg: shared types and helpers for the first-order IIR audio filter.
//   state_t   - sequencing FSM states
//   term_t    - which product term the serial MAC is working on
//   round_sat - Q-format round-half-up, arithmetic shift and saturation
// Optional build macro used elsewhere in this slice: AUDIO_IIR_SAT_COUNT_EN.
package audio_pkg;

    typedef enum logic [1:0] {IDLE_S, MUL_S, ROUND_S, OUT_S} state_t;

    typedef enum logic [1:0] {TERM_B0, TERM_B1, TERM_A1} term_t;

    // Working width for round_sat; wide enough for any sane accumulator.
    localparam int RS_W = 64;

    typedef struct packed {
        logic signed [RS_W-1:0] value;
        logic                   clipped;
    } round_sat_t;

    // Adds half an LSB of the result, shifts right by frac_bits (floor),
    // then clamps to the signed data_w range.
    function automatic round_sat_t round_sat(
        input logic signed [RS_W-1:0] acc,
        input int                     frac_bits,
        input int                     data_w
    );
        logic signed [RS_W-1:0] half;
        logic signed [RS_W-1:0] rounded;
        logic signed [RS_W-1:0] max_v;
        logic signed [RS_W-1:0] min_v;
        round_sat_t             r;
        half    = 64'sd1 <<< (frac_bits - 1);
        rounded = (acc + half) >>> frac_bits;
        max_v   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v   = ~max_v;
        r.clipped = 1'b0;
        r.value   = rounded;
        if (rounded > max_v) begin
            r.value   = max_v;
            r.clipped = 1'b1;
        end else if (rounded < min_v) begin
            r.value   = min_v;
            r.clipped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_mac.sv
// serial_mac: bit-serial shift-add multiply-accumulate, one coefficient bit
// per cycle, LSB first. The coefficient is signed two's complement, so its
// top bit subtracts instead of adds. The accumulator keeps running across
// terms; only start clears it.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - clear accumulator and bit counter
//   run         - process one coefficient bit this cycle
//   operand     - signed multiplicand (sign-extended internally)
//   coeff       - signed coefficient, held stable for the whole term
//   acc         - running signed accumulator
//   done        - high on the cycle the last (sign) bit is processed
module serial_mac #(
    parameter int OperandWidth = 12,
    parameter int CoeffWidth   = 8,
    parameter int AccWidth     = 22
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       run,
    input  logic signed [OperandWidth-1:0] operand,
    input  logic        [CoeffWidth-1:0]   coeff,
    output logic signed [AccWidth-1:0]     acc,
    output logic                       done
);

    localparam int BitCntW = $clog2(CoeffWidth);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(CoeffWidth - 1);

    logic [BitCntW-1:0]         bit_cnt;
    logic signed [AccWidth-1:0] shifted;

    assign shifted = AccWidth'(operand) <<< bit_cnt;
    assign done    = run && (bit_cnt == LastBit);

    always_ff @(posedge clk) begin
        if (reset || start) begin
            acc     <= '0;
            bit_cnt <= '0;
        end else if (run) begin
            if (coeff[bit_cnt]) begin
                acc <= (bit_cnt == LastBit) ? acc - shifted : acc + shifted;
            end
            bit_cnt <= (bit_cnt == LastBit) ? '0 : bit_cnt + BitCntW'(1);
        end
    end

endmodule

// File: rtl/audio_iir_filter.sv
// audio_iir_filter: first-order IIR, y[n] = b0*x[n] + b1*x[n-1] + a1*y[n-1],
// sitting between the I2S ADC and DAC ports. One serial MAC is reused for
// all three products; latency is 3*CoeffWidth+2 cycles (1 in bypass).
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   enable           - 1 filter, 0 bypass (sampled at acceptance)
//   b0, b1, a1       - signed Q1.(CoeffWidth-1) coefficients
//   inData           - signed input sample, inDataValid rising edge = new sample
//   outData          - signed output sample, holds between pulses
//   outDataValid     - one-cycle pulse with each new outData
//   busy             - FSM not idle
//   dropped          - sticky: a sample edge arrived while busy
//   satCount         - saturation event counter, only with AUDIO_IIR_SAT_COUNT_EN
//
// state   | meaning
// IDLE_S  | waiting for an inDataValid rising edge
// MUL_S   | serial MAC over terms (b0,x), (b1,x1), (a1,y1)
// ROUND_S | round, shift, saturate accumulator into outData
// OUT_S   | present outData, update history
module audio_iir_filter
    import audio_pkg::*;
#(
    parameter int DataWidth  = 12,
    parameter int CoeffWidth = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CoeffWidth-1:0] b0,
    input  logic [CoeffWidth-1:0] b1,
    input  logic [CoeffWidth-1:0] a1,
    input  logic [DataWidth-1:0]  inData,
    input  logic                  inDataValid,
    output logic [DataWidth-1:0]  outData,
    output logic                  outDataValid,
    output logic                  busy,
`ifdef AUDIO_IIR_SAT_COUNT_EN
    output logic [7:0]            satCount,
`endif
    output logic                  dropped
);

    localparam int AccWidth = DataWidth + CoeffWidth + 2;

    state_t state_q, state_d;
    term_t  term_q;

    logic                        valid_q;
    logic                        edge_seen;
    logic signed [DataWidth-1:0] x_q, x1_q, y1_q, out_q;
    logic [CoeffWidth-1:0]       b0_q, b1_q, a1_q;
    logic                        en_q;
    logic                        dropped_q;

    logic signed [DataWidth-1:0] mac_operand;
    logic [CoeffWidth-1:0]       mac_coeff;
    logic signed [AccWidth-1:0]  acc;
    logic                        mac_done;
    round_sat_t                  rs;
    logic                        unused_rs_hi;

    assign edge_seen = inDataValid && !valid_q;

    always_comb begin
        mac_operand = x_q;
        mac_coeff   = b0_q;
        case (term_q)
            TERM_B1: begin
                mac_operand = x1_q;
                mac_coeff   = b1_q;
            end
            TERM_A1: begin
                mac_operand = y1_q;
                mac_coeff   = a1_q;
            end
            default: ;
        endcase
    end

    serial_mac #(
        .OperandWidth(DataWidth),
        .CoeffWidth  (CoeffWidth),
        .AccWidth    (AccWidth)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .start  (state_q == IDLE_S && edge_seen),
        .run    (state_q == MUL_S),
        .operand(mac_operand),
        .coeff  (mac_coeff),
        .acc    (acc),
        .done   (mac_done)
    );

    assign rs           = round_sat(RS_W'(acc), CoeffWidth - 1, DataWidth);
    assign unused_rs_hi = ^rs.value[RS_W-1:DataWidth];

    always_comb begin
        state_d      = state_q;
        outDataValid = 1'b0;
        busy         = 1'b1;
        case (state_q)
            IDLE_S: begin
                busy = 1'b0;
                if (edge_seen) state_d = enable ? MUL_S : OUT_S;
            end
            MUL_S:   if (mac_done && term_q == TERM_A1) state_d = ROUND_S;
            ROUND_S: state_d = OUT_S;
            OUT_S: begin
                outDataValid = 1'b1;
                state_d      = IDLE_S;
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE_S;
            term_q    <= TERM_B0;
            valid_q   <= 1'b0;
            x_q       <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            out_q     <= '0;
            b0_q      <= '0;
            b1_q      <= '0;
            a1_q      <= '0;
            en_q      <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            valid_q <= inDataValid;
            state_q <= state_d;
            if (edge_seen && state_q != IDLE_S) dropped_q <= 1'b1;
            case (state_q)
                IDLE_S: if (edge_seen) begin
                    x_q    <= inData;
                    b0_q   <= b0;
                    b1_q   <= b1;
                    a1_q   <= a1;
                    en_q   <= enable;
                    term_q <= TERM_B0;
                    if (!enable) begin
                        out_q <= inData;
                        x1_q  <= '0;
                        y1_q  <= '0;
                    end
                end
                MUL_S: if (mac_done) begin
                    case (term_q)
                        TERM_B0: term_q <= TERM_B1;
                        TERM_B1: term_q <= TERM_A1;
                        default: term_q <= TERM_B0;
                    endcase
                end
                ROUND_S: out_q <= rs.value[DataWidth-1:0];
                // Bypass leaves the history cleared so filtering restarts fresh.
                OUT_S: if (en_q) begin
                    x1_q <= x_q;
                    y1_q <= out_q;
                end
                default: ;
            endcase
        end
    end

`ifdef AUDIO_IIR_SAT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            satCount <= '0;
        end else if (state_q == ROUND_S && rs.clipped && satCount != 8'hFF) begin
            satCount <= satCount + 8'd1;
        end
    end
`endif

    assign outData = out_q;
    assign dropped = dropped_q;

endmodule
